uart_tx_io: RTL and testbench

- Memory-mapped UART transmitter; the outbound counterpart to the bootloader's RX path.
- Lets CPU software stream bytes (debug prints, coprocessor status, memory dumps) out of the FPGA over TX, 8N1, LSB first.
- Sits beside the I/O layer: byte writes push into an internal FIFO; status bits are returned for IO reads.

---
 rtl/uart_tx_io_pkg.sv | 16 +
 rtl/uart_tx_io_fifo.sv | 67 ++++++
 rtl/uart_tx_io.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_io.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_io_pkg.sv
// Shared UART constants and the transmit state type.
// The bootloader's RX path reuses the baud constant from here.
package common_params;

  localparam int UART_BAUD_DIV = 434;
  localparam int DATA_BITS     = 8;
  localparam int STOP_BITS     = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_io_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// The RX side can reuse it as well.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // Full and empty come from the registered count, so a byte pushed this
  // cycle is never visible to a pop in the same cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: CPU byte writes queue into a FIFO
// and are shifted out LSB first on TX, with status bits for IO reads.
module uart_tx_io
  import common_params::*;
#(
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr_ovf,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] count,
  output logic             TX
);

  localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  tx_state_t              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;

  logic                   baudEnd;
  logic                   fifoPop;
  logic [7:0]             fifoData;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [CNT_W-1:0]       fifoCount;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (fifoPop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign baudEnd = (baud_q == BAUD_W'(BAUD_DIV - 1));

  // TX is registered from the current state, so the line trails the FSM by
  // one cycle; every level still lasts exactly BAUD_DIV cycles.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifoPop  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baudEnd ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoData;
          baud_d  = '0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baudEnd) begin
          bitIdx_d = '0;
          state_d  = DATA;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (baudEnd) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == BIT_W'(DATA_BITS - 1)) begin
            bitIdx_d = '0;
            state_d  = STOP;
          end else begin
            bitIdx_d = bitIdx_q + BIT_W'(1);
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baudEnd) begin
          if (bitIdx_q == BIT_W'(STOP_BITS - 1)) begin
            bitIdx_d = '0;
            if (!fifoEmpty) begin
              fifoPop = 1'b1;
              shift_d = fifoData;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitIdx_d = bitIdx_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A dropped write wins over a simultaneous clear so no overflow is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifoFull) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  assign TX    = tx_q;
  assign ovf   = ovf_q;
  assign full  = fifoFull;
  assign empty = fifoEmpty;
  assign count = fifoCount;
  assign busy  = (state_q != IDLE) | ~fifoEmpty;

endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io at BAUD_DIV=4, FIFO_DEPTH=8: a
// frame-position model checks every cycle, a line decoder checks byte order.
module tb_uart_tx_io;

  localparam int BD    = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * BD;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;
  logic [3:0] count;
  logic       TX;

  int checks = 0;
  int errors = 0;

  uart_tx_io #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .ovf     (ovf),
    .count   (count),
    .TX      (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bytes waiting, plus the position inside the frame on the line.
  byte unsigned mq[$];
  bit           mActive;
  int           mPos;
  byte unsigned mByte;
  bit           mOvf;
  bit           mTx;
  bit           modelValid = 1'b0;
  int           mSize;
  int           mBit;
  bit           mDoPop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mActive    = 1'b0;
      mPos       = 0;
      mOvf       = 1'b0;
      mTx        = 1'b1;
      modelValid = 1'b1;
    end else if (modelValid) begin
      mSize = mq.size();
      if (mActive) begin
        mBit = mPos / BD;
        if (mBit == 0)      mTx = 1'b0;
        else if (mBit <= 8) mTx = mByte[mBit-1];
        else                mTx = 1'b1;
      end else begin
        mTx = 1'b1;
      end
      mDoPop = (mSize > 0) && (!mActive || mPos == FRAME - 1);
      if (wr_en && mSize == DEPTH) mOvf = 1'b1;
      else if (clr_ovf)            mOvf = 1'b0;
      if (mActive && mPos != FRAME - 1) begin
        mPos = mPos + 1;
      end else if (mDoPop) begin
        mByte   = mq.pop_front();
        mActive = 1'b1;
        mPos    = 0;
      end else begin
        mActive = 1'b0;
      end
      if (wr_en && mSize < DEPTH) mq.push_back(wr_data);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("tx",    TX,    mTx);
      checkOutput("count", count, mq.size());
      checkOutput("empty", empty, mq.size() == 0);
      checkOutput("full",  full,  mq.size() == DEPTH);
      checkOutput("busy",  busy,  mActive || mq.size() > 0);
      checkOutput("ovf",   ovf,   mOvf);
    end
  end

  // Line decoder: samples each data bit two cycles into its period.
  byte unsigned decQ[$];
  byte unsigned expQ[$];
  bit           rxActive = 1'b0;
  int           rxCnt;
  logic [7:0]   rxByte;

  always @(negedge clk) begin
    if (!rxActive) begin
      if (modelValid && TX === 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 1;
      end
    end else begin
      if (rxCnt >= 6 && rxCnt <= 34 && (rxCnt % 4) == 2) rxByte = {TX, rxByte[7:1]};
      if (rxCnt == FRAME - 1) begin
        decQ.push_back(rxByte);
        rxActive = 1'b0;
      end else begin
        rxCnt++;
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [7:0] data,
                               input logic clr, input logic rstv);
    @(negedge clk);
    wr_en   = we;
    wr_data = data;
    clr_ovf = clr;
    rst     = rstv;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (busy && n < maxCycles) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    checkOutput("wait_idle_timeout", busy, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkDecoded(input string name);
    checkOutput({name, "_len"}, decQ.size(), expQ.size());
    for (int i = 0; i < decQ.size() && i < expQ.size(); i++)
      checkOutput(name, decQ[i], expQ[i]);
    decQ.delete();
    expQ.delete();
  endtask

  logic [0:43] txObs;
  logic [0:43] busyObs;
  logic [0:43] expTx;
  int          peak;
  bit          sawLow;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    rst     = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Idle after reset
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_tx",    TX,    1'b1);
    checkOutput("t1_empty", empty, 1'b1);
    checkOutput("t1_busy",  busy,  1'b0);
    checkOutput("t1_ovf",   ovf,   1'b0);
    checkOutput("t1_count", count, 4'd0);

    // Single byte 0xA5: hand-written waveform relative to the write edge
    expTx = {2'b11, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000,
             4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b11};
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 44; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      txObs[i]   = TX;
      busyObs[i] = busy;
    end
    checkOutput("t2_wave",    txObs,       expTx);
    checkOutput("t2_busy_40", busyObs[40], 1'b1);
    checkOutput("t2_busy_41", busyObs[41], 1'b0);
    waitIdle(100);
    expQ = '{8'hA5};
    checkDecoded("t2_byte");

    // Back-to-back frames
    peak = 0;
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    if (int'(count) > peak) peak = int'(count);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    if (int'(count) > peak) peak = int'(count);
    repeat (10) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      if (int'(count) > peak) peak = int'(count);
    end
    checkOutput("t3_peak", peak, 2);
    waitIdle(300);
    expQ = '{8'h00, 8'hFF, 8'h55};
    checkDecoded("t3_bytes");

    // Overflow while a frame is on the line
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4_count_full", count, 4'd8);
    checkOutput("t4_full",       full,  1'b1);
    checkOutput("t4_ovf_set",    ovf,   1'b1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("t4_ovf_clr",    ovf,   1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_ovf_prio",   ovf,   1'b1);
    checkOutput("t4_count_keep", count, 4'd8);
    waitIdle(600);
    expQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    checkDecoded("t4_bytes");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_ovf_final", ovf, 1'b0);

    // Reset during data bit 3 of 0x3C with four bytes queued
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    repeat (13) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_count_pre", count, 4'd4);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_tx",    TX,    1'b1);
    checkOutput("t5_count", count, 4'd0);
    checkOutput("t5_busy",  busy,  1'b0);
    checkOutput("t5_empty", empty, 1'b1);
    sawLow = 1'b0;
    repeat (60) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      if (TX !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("t5_no_frame", sawLow, 1'b0);
    decQ.delete();

    // Dropped write in the same cycle as a pop, then pointer wrap
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_count_full", count, 4'd8);
    checkOutput("t6_full",       full,  1'b1);
    repeat (31) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_count_after", count, 4'd7);
    checkOutput("t6_ovf",         ovf,   1'b1);
    checkOutput("t6_not_full",    full,  1'b0);
    waitIdle(500);
    expQ = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
    checkDecoded("t6_fill");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      repeat (29) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    waitIdle(1000);
    for (int i = 0; i < 20; i++) expQ.push_back(8'h60 + 8'(i));
    checkDecoded("t6_wrap");
    checkOutput("t6_ovf_clear", ovf, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
